axi4_ar_decode_check: RTL

AXI4_AR_DECODE_CHECK -- requirements
Module: axi4_ar_decode_check

---
 rtl/axi4_ar_decode_check.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/axi4_ar_decode_check.sv
// AXI4 read-address decoder with per-master access check. Permitted ARs are
// registered and forwarded; rejected ARs are answered locally with a DECERR burst.
//
//   state | meaning
//   IDLE  | ready for a new AR (s_arready=1)
//   FWD   | holding a permitted AR on m_ar* until m_arready
//   ERR   | issuing s_arlen+1 DECERR beats on err_r*
module axi4_ar_decode_check #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int ID_WIDTH      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int MASTER_ID     = 0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_arvalid,
  output logic                     s_arready,
  input  logic [ADDRESS_WIDTH-1:0] s_araddr,
  input  logic [ID_WIDTH-1:0]      s_arid,
  input  logic [7:0]               s_arlen,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [ADDRESS_WIDTH-1:0] m_araddr,
  output logic [ID_WIDTH-1:0]      m_arid,
  output logic [7:0]               m_arlen,
  output logic [1:0]               m_arsel,
  output logic                     err_rvalid,
  input  logic                     err_rready,
  output logic [ID_WIDTH-1:0]      err_rid,
  output logic [DATA_WIDTH-1:0]    err_rdata,
  output logic [1:0]               err_rresp,
  output logic                     err_rlast,
  output logic [15:0]              dec_err_cnt
);

  typedef logic [ADDRESS_WIDTH:0] addr_ext_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_ERR} state_t;

  localparam addr_ext_t S0_BASE = addr_ext_t'(64'h0000_0100_0000_0000);
  localparam addr_ext_t S0_SIZE = addr_ext_t'(64'h0000_0008_0000_0000);
  localparam addr_ext_t S1_BASE = addr_ext_t'(64'h0000_0000_0000_0000);
  localparam addr_ext_t S1_SIZE = addr_ext_t'(64'h0000_0000_0002_0000);
  localparam addr_ext_t S2_BASE = addr_ext_t'(64'h0000_0010_0000_0000);
  localparam addr_ext_t S2_SIZE = addr_ext_t'(64'h0000_0000_0010_0000);
  localparam addr_ext_t S3_BASE = addr_ext_t'(64'h0000_0020_0000_0000);
  localparam addr_ext_t S3_SIZE = addr_ext_t'(64'h0000_0000_0000_1000);

  // bit i set = slave i reachable from this master
  localparam logic [3:0] PERM = (MASTER_ID == 0) ? 4'b1101 :
                                (MASTER_ID == 1) ? 4'b0101 :
                                (MASTER_ID == 2) ? 4'b0101 :
                                (MASTER_ID == 3) ? 4'b1001 : 4'b0000;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_araddr;
  logic [ID_WIDTH-1:0]      r_arid;
  logic [7:0]               r_arlen;
  logic [1:0]               r_arsel;
  logic [ID_WIDTH-1:0]      r_err_rid;
  logic [7:0]               r_beat_cnt;
  logic [15:0]              r_dec_err_cnt;

  addr_ext_t  w_addr_ext;
  logic [3:0] w_hit;
  logic [1:0] w_sel;
  logic       w_ok;
  logic       w_accept;
  logic       w_err_hs;

  // base <= addr < base+size as (addr-base) < size: the wider subtraction wraps
  // far above any size when addr < base, so no overflow case exists.
  always_comb begin
    w_addr_ext = {1'b0, s_araddr};
    w_hit[0]   = (w_addr_ext - S0_BASE) < S0_SIZE;
    w_hit[1]   = (w_addr_ext - S1_BASE) < S1_SIZE;
    w_hit[2]   = (w_addr_ext - S2_BASE) < S2_SIZE;
    w_hit[3]   = (w_addr_ext - S3_BASE) < S3_SIZE;
    w_ok       = |(w_hit & PERM);
    w_sel      = 2'd0;
    if (w_hit[1])      w_sel = 2'd1;
    else if (w_hit[2]) w_sel = 2'd2;
    else if (w_hit[3]) w_sel = 2'd3;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_arready   = 1'b0;
    m_arvalid   = 1'b0;
    err_rvalid  = 1'b0;
    err_rlast   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) w_state_nxt = w_ok ? ST_FWD : ST_ERR;
      end
      ST_FWD: begin
        m_arvalid = 1'b1;
        if (m_arready) w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        err_rvalid = 1'b1;
        err_rlast  = (r_beat_cnt == 8'd0);
        if (err_rready && r_beat_cnt == 8'd0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && s_arvalid;
  assign w_err_hs = (r_state == ST_ERR) && err_rready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_araddr      <= '0;
      r_arid        <= '0;
      r_arlen       <= '0;
      r_arsel       <= '0;
      r_err_rid     <= '0;
      r_beat_cnt    <= '0;
      r_dec_err_cnt <= '0;
    end else if (w_accept && w_ok) begin
      r_araddr <= s_araddr;
      r_arid   <= s_arid;
      r_arlen  <= s_arlen;
      r_arsel  <= w_sel;
    end else if (w_accept) begin
      r_err_rid  <= s_arid;
      r_beat_cnt <= s_arlen;
      if (r_dec_err_cnt != 16'hFFFF) r_dec_err_cnt <= r_dec_err_cnt + 16'd1;
    end else if (w_err_hs && r_beat_cnt != 8'd0) begin
      r_beat_cnt <= r_beat_cnt - 8'd1;
    end
  end

  assign m_araddr    = r_araddr;
  assign m_arid      = r_arid;
  assign m_arlen     = r_arlen;
  assign m_arsel     = r_arsel;
  assign err_rid     = r_err_rid;
  assign err_rdata   = '0;
  assign err_rresp   = 2'b11;
  assign dec_err_cnt = r_dec_err_cnt;

endmodule
